// File: rtl/neuron_mac_seq.sv
// Single serial neuron: saturating multiply-accumulate over N_INPUTS activations on top of a bias,
// then a selectable activation, with valid/ready streams on both sides and per-address weight load.
module neuron_mac_seq #(
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned BIT_SIZE  = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_we,
    input  logic [$clog2(N_INPUTS)-1:0] w_addr,
    input  logic [BIT_SIZE-1:0]         w_data,
    input  logic [BIT_SIZE-1:0]         bias,
    input  logic [1:0]                  act_mode,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [BIT_SIZE-1:0]         x_data,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic [BIT_SIZE-1:0]         y_data,
    output logic                        busy
);
    localparam int unsigned AW = $clog2(N_INPUTS);
    localparam int unsigned PW = 2 * BIT_SIZE;
    localparam logic signed [PW-1:0] MAX_V = {{(BIT_SIZE+1){1'b0}}, {(BIT_SIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(BIT_SIZE+1){1'b1}}, {(BIT_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} state_t;

    state_t                     state, state_d;
    logic signed [BIT_SIZE-1:0] w_mem [N_INPUTS];
    logic signed [BIT_SIZE-1:0] acc, acc_d;
    logic [AW-1:0]              count, count_d;
    logic [1:0]                 mode, mode_d;
    logic                       y_valid_d;
    logic [BIT_SIZE-1:0]        y_data_d;

    logic                       accept_c;
    logic                       w_wr_c;
    logic [AW-1:0]              w_idx_c;
    logic signed [BIT_SIZE-1:0] w_sel_c;
    logic signed [PW-1:0]       x_ext_c, w_ext_c, full_c;
    logic signed [BIT_SIZE-1:0] prod_c, base_c, sum_c, act_c;

    // Clamp a wide signed value into the BIT_SIZE two's-complement range.
    function automatic logic signed [BIT_SIZE-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAX_V) return BIT_SIZE'(MAX_V);
        if (v < MIN_V) return BIT_SIZE'(MIN_V);
        return BIT_SIZE'(v);
    endfunction

    assign x_ready  = !rst && ((state == IDLE) || (state == ACC));
    assign accept_c = x_valid && x_ready;
    assign w_wr_c   = w_we && (state == IDLE) && !x_valid && (32'(w_addr) < N_INPUTS);

    // Product path: full-width signed multiply, floor shift back to Q format, clamp.
    assign w_idx_c = (state == IDLE) ? '0 : count;
    assign w_sel_c = w_mem[w_idx_c];
    assign x_ext_c = {{BIT_SIZE{x_data[BIT_SIZE-1]}}, x_data};
    assign w_ext_c = {{BIT_SIZE{w_sel_c[BIT_SIZE-1]}}, w_sel_c};
    assign full_c  = x_ext_c * w_ext_c;
    assign prod_c  = sat(full_c >>> FRAC_BITS);

    // First accept starts from the bias, later accepts from the running sum.
    assign base_c = (state == IDLE) ? $signed(bias) : acc;
    assign sum_c  = sat({{BIT_SIZE{base_c[BIT_SIZE-1]}}, base_c} + {{BIT_SIZE{prod_c[BIT_SIZE-1]}}, prod_c});

    always_comb begin
        act_c = acc;
        case (mode)
            2'd1:    act_c = acc[BIT_SIZE-1] ? '0 : acc;
            2'd2:    act_c = acc[BIT_SIZE-1] ? (acc >>> 3) : acc;
            default: act_c = acc;
        endcase
    end

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        count_d   = count;
        mode_d    = mode;
        y_valid_d = y_valid;
        y_data_d  = y_data;
        case (state)
            IDLE: if (accept_c) begin
                acc_d   = sum_c;
                count_d = AW'(1);
                mode_d  = act_mode;
                state_d = ACC;
            end
            ACC: if (accept_c) begin
                acc_d   = sum_c;
                count_d = count + AW'(1);
                if (count == AW'(N_INPUTS - 1)) begin
                    count_d = '0;
                    state_d = ACT;
                end
            end
            ACT: begin
                y_data_d  = act_c;
                y_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: if (y_ready) begin
                y_valid_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            mode    <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            count   <= count_d;
            mode    <= mode_d;
            y_valid <= y_valid_d;
            y_data  <= y_data_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Weight store; writes only land while idle with no input offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_INPUTS); i++) w_mem[i] <= '0;
        end else if (w_wr_c) begin
            w_mem[w_addr] <= $signed(w_data);
        end
    end
endmodule
